// File: rtl/pmips_pkg.sv
// rtl/pmips_pkg.sv - shared PMIPS data-memory address map and decoder helpers
package pmips_pkg;

  localparam logic [15:0] ADDR_LED  = 16'hFF00;
  localparam logic [15:0] ADDR_IN   = 16'hFF02;
  localparam logic [15:0] ADDR_CYC  = 16'hFF04;
  localparam logic [15:0] ADDR_TICK = 16'hFF06;
  localparam logic [7:0]  IO_PAGE   = 8'hFF;

  typedef enum logic [1:0] {RGN_RAM, RGN_IO, RGN_UNMAPPED} region_e;
  typedef enum logic [1:0] {IO_LED, IO_IN, IO_CYC, IO_TICK} io_reg_e;

  // Byte bit 0 is ignored everywhere, so decode on the word-aligned address.
  // The I/O page is checked first so a very large RAM can never shadow it.
  function automatic region_e decode_region(input logic [15:0] addr,
                                            input int unsigned ram_bytes);
    logic [15:0] word;
    word = addr & 16'hFFFE;
    if (word[15:8] == IO_PAGE &&
        (word == ADDR_LED || word == ADDR_IN || word == ADDR_CYC || word == ADDR_TICK))
      return RGN_IO;
    if (32'(word) < ram_bytes)
      return RGN_RAM;
    return RGN_UNMAPPED;
  endfunction

endpackage

// File: rtl/dmem_io_bridge_if.sv
// rtl/dmem_io_bridge_if.sv - MEM-stage data bus between core and dmem_io_bridge
interface dmem_io_bridge_if;
  logic [15:0] dmemaddr;
  logic [15:0] dmemwdata;
  logic        dmemwrite;
  logic        dmemread;
  logic [15:0] dmemrdata;

  modport master (output dmemaddr, output dmemwdata, output dmemwrite, output dmemread,
                  input dmemrdata);
  modport slave  (input dmemaddr, input dmemwdata, input dmemwrite, input dmemread,
                  output dmemrdata);
endinterface

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - input synchronizer with optional debounce (DMEM_IO_DEBOUNCE_EN)
module io_debounce #(
  parameter int WIDTH = 8
`ifdef DMEM_IO_DEBOUNCE_EN
  , parameter int DB_CYCLES = 16
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] clean
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  // Two-flop synchronizer for the asynchronous board pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef DMEM_IO_DEBOUNCE_EN
  localparam int CW = ($clog2(DB_CYCLES) > 0) ? $clog2(DB_CYCLES) : 1;

  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] state;

  // Per-bit counter of consecutive cycles at a new level; any return to the
  // accepted level restarts it, and the DB_CYCLES-th differing cycle commits.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == state[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
          state[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign clean = state;
`else
  assign clean = sync2;
`endif

endmodule

// File: rtl/dmem_io_bridge.sv
// rtl/dmem_io_bridge.sv - PMIPS data RAM plus LED/IN/CYC/TICK I/O (debounce: DMEM_IO_DEBOUNCE_EN)
module dmem_io_bridge
  import pmips_pkg::*;
#(
  parameter int RAM_WORDS = 128,
  parameter int PRESCALE  = 50000
`ifdef DMEM_IO_DEBOUNCE_EN
  , parameter int DB_CYCLES = 16
`endif
) (
  input  logic                clock,
  input  logic                reset,
  dmem_io_bridge_if.slave     bus,
  input  logic [3:0]          sw_in,
  input  logic [3:0]          btn_in,
  output logic [7:0]          led,
  output logic                err_unmapped
);

  localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int          PW        = $clog2(PRESCALE);
  localparam int unsigned RAM_BYTES = 2 * RAM_WORDS;

  logic [15:0]   ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  region_e       rgn;
  io_reg_e       io_sel;
  logic          wr_ram;
  logic          wr_led;
  logic          wr_cyc;
  logic          wr_tick;
  logic          bad_access;
  logic [15:0]   cyc;
  logic [15:0]   tick;
  logic [PW-1:0] pre;
  logic [7:0]    in_word;
  logic [15:0]   rdata;

  io_debounce #(
    .WIDTH(8)
`ifdef DMEM_IO_DEBOUNCE_EN
    , .DB_CYCLES(DB_CYCLES)
`endif
  ) u_in (
    .clock (clock),
    .reset (reset),
    .raw   ({btn_in, sw_in}),
    .clean (in_word)
  );

  assign ram_idx = bus.dmemaddr[AW:1];

  // Address decode and per-target write strobes; IN and unmapped stores drop.
  always_comb begin
    rgn = decode_region(bus.dmemaddr, RAM_BYTES);
    case (bus.dmemaddr & 16'hFFFE)
      ADDR_IN:   io_sel = IO_IN;
      ADDR_CYC:  io_sel = IO_CYC;
      ADDR_TICK: io_sel = IO_TICK;
      default:   io_sel = IO_LED;
    endcase
    wr_ram     = bus.dmemwrite && (rgn == RGN_RAM);
    wr_led     = bus.dmemwrite && (rgn == RGN_IO) && (io_sel == IO_LED);
    wr_cyc     = bus.dmemwrite && (rgn == RGN_IO) && (io_sel == IO_CYC);
    wr_tick    = bus.dmemwrite && (rgn == RGN_IO) && (io_sel == IO_TICK);
    bad_access = (bus.dmemread || bus.dmemwrite) && (rgn == RGN_UNMAPPED);
  end

  // Zero-latency read mux from pre-edge state; zero when not reading.
  always_comb begin
    rdata = 16'h0000;
    if (bus.dmemread) begin
      case (rgn)
        RGN_RAM: rdata = ram[ram_idx];
        RGN_IO: begin
          case (io_sel)
            IO_LED:  rdata = {8'h00, led};
            IO_IN:   rdata = {8'h00, in_word};
            IO_CYC:  rdata = cyc;
            default: rdata = tick;
          endcase
        end
        default: rdata = 16'h0000;
      endcase
    end
  end

  assign bus.dmemrdata = rdata;

  // RAM store; contents survive reset but a store during reset is dropped.
  always_ff @(posedge clock) begin
    if (!reset && wr_ram) ram[ram_idx] <= bus.dmemwdata;
  end

  // LED register and sticky unmapped-access flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      led          <= 8'h00;
      err_unmapped <= 1'b0;
    end else begin
      if (wr_led) led <= bus.dmemwdata[7:0];
      if (bad_access) err_unmapped <= 1'b1;
    end
  end

  // Free-running cycle counter; a store clears it and wins over the increment.
  always_ff @(posedge clock) begin
    if (reset || wr_cyc) cyc <= 16'h0000;
    else                 cyc <= cyc + 16'd1;
  end

  // Prescaled tick counter; a store clears both tick and prescaler.
  always_ff @(posedge clock) begin
    if (reset || wr_tick) begin
      pre  <= '0;
      tick <= 16'h0000;
    end else if (pre == PW'(PRESCALE - 1)) begin
      pre  <= '0;
      tick <= tick + 16'd1;
    end else begin
      pre <= pre + PW'(1);
    end
  end

endmodule

// File: tb/tb_dmem_io_bridge.sv
// tb/tb_dmem_io_bridge.sv - self-checking bench for dmem_io_bridge
module tb_dmem_io_bridge;

  localparam int RW = 128;
  localparam int PS = 4;
`ifdef DMEM_IO_DEBOUNCE_EN
  localparam int DB  = 16;
  localparam int DBL = DB;
`else
  localparam int DBL = 0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] sw_in;
  logic [3:0] btn_in;
  logic [7:0] led;
  logic       err_unmapped;

  dmem_io_bridge_if bus();

  dmem_io_bridge #(
    .RAM_WORDS(RW),
    .PRESCALE(PS)
`ifdef DMEM_IO_DEBOUNCE_EN
    , .DB_CYCLES(DB)
`endif
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .sw_in        (sw_in),
    .btn_in       (btn_in),
    .led          (led),
    .err_unmapped (err_unmapped)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: counters derived from the cycle index of their last clear.
  bit          started = 1'b0;
  int          n = 0;
  int          c0 = 0;
  int          t0 = 0;
  int          r_n = 0;
  logic [15:0] ram_m [RW];
  bit          ram_v [RW];
  logic [7:0]  led_m = 8'h00;
  bit          err_m = 1'b0;
  logic [7:0]  db_m = 8'h00;
  logic [7:0]  pin_hist [0:131071];
  logic [7:0]  pins = 8'h00;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] synced(input int j);
    if (j - r_n < 2) return 8'h00;
    return pin_hist[j-2];
  endfunction

  function automatic logic [7:0] exp_in();
`ifdef DMEM_IO_DEBOUNCE_EN
    return db_m;
`else
    return synced(n);
`endif
  endfunction

  function automatic bit unmapped(input logic [15:0] addr);
    int a;
    a = int'(addr) & 32'hFFFE;
    return !(a < 2*RW || a == 32'hFF00 || a == 32'hFF02 || a == 32'hFF04 || a == 32'hFF06);
  endfunction

  function automatic bit exp_read(input logic [15:0] addr, input bit rd, output logic [15:0] v);
    int a;
    a = int'(addr) & 32'hFFFE;
    v = 16'h0000;
    if (!rd) return 1'b1;
    if (a < 2*RW) begin
      if (!ram_v[a/2]) return 1'b0;
      v = ram_m[a/2];
      return 1'b1;
    end
    case (a)
      32'hFF00: v = {8'h00, led_m};
      32'hFF02: v = {8'h00, exp_in()};
      32'hFF04: v = 16'((n - c0) & 32'hFFFF);
      32'hFF06: v = 16'(((n - t0) / PS) & 32'hFFFF);
      default:  v = 16'h0000;
    endcase
    return 1'b1;
  endfunction

  task automatic step(input bit rst, input bit rd, input bit wr, input logic [15:0] addr,
                      input logic [15:0] wd, input bit has_lit, input logic [15:0] lit,
                      input string tag);
    logic [15:0] ev;
    logic [7:0]  s;
    logic [7:0]  lvl;
    bit          known;
    bit          stable;
    int          a;
    reset = rst;
    bus.dmemread = rd;
    bus.dmemwrite = wr;
    bus.dmemaddr = addr;
    bus.dmemwdata = wd;
    {btn_in, sw_in} = pins;
    #1;
    if (started) begin
      known = exp_read(addr, rd, ev);
      if (known) chk({tag, "_model"}, bus.dmemrdata, ev);
      chk("led", {8'h00, led}, {8'h00, led_m});
      chk("err_unmapped", {15'h0, err_unmapped}, {15'h0, err_m});
    end
    if (has_lit) chk(tag, bus.dmemrdata, lit);
    @(posedge clock);
    pin_hist[n] = pins;
    if (rst) begin
      led_m = 8'h00;
      err_m = 1'b0;
      db_m = 8'h00;
      n++;
      c0 = n;
      t0 = n;
      r_n = n;
      started = 1'b1;
    end else begin
      if ((rd || wr) && unmapped(addr)) err_m = 1'b1;
      if (wr) begin
        a = int'(addr) & 32'hFFFE;
        if (a < 2*RW) begin
          ram_m[a/2] = wd;
          ram_v[a/2] = 1'b1;
        end else if (a == 32'hFF00) led_m = wd[7:0];
        else if (a == 32'hFF04) c0 = n + 1;
        else if (a == 32'hFF06) t0 = n + 1;
      end
`ifdef DMEM_IO_DEBOUNCE_EN
      lvl = synced(n);
      for (int b = 0; b < 8; b++) begin
        stable = 1'b1;
        for (int j = n - DB + 1; j < n; j++) begin
          if (j < r_n) stable = 1'b0;
          else begin
            s = synced(j);
            if (s[b] != lvl[b]) stable = 1'b0;
          end
        end
        if (stable && lvl[b] != db_m[b]) db_m[b] = lvl[b];
      end
`else
      s = 8'h00;
      lvl = s;
      stable = 1'b0;
`endif
      n++;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, "idle");
  endtask

  task automatic rd_lit(input logic [15:0] addr, input logic [15:0] lit, input string tag);
    step(1'b0, 1'b1, 1'b0, addr, 16'h0000, 1'b1, lit, tag);
  endtask

  task automatic wr_word(input logic [15:0] addr, input logic [15:0] data);
    step(1'b0, 1'b0, 1'b1, addr, data, 1'b0, 16'h0000, "wr");
  endtask

  initial begin
    logic [15:0] ad;
    bit          r;
    bit          w;
    bit          rs;
    int          sel;

    // Reset and RAM basics.
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, "rst");
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, "rst");
    chk("reset_led", {8'h00, led}, 16'h0000);
    chk("reset_err", {15'h0, err_unmapped}, 16'h0000);
    rd_lit(16'hFF04, 16'h0000, "reset_cyc");
    wr_word(16'h0010, 16'h1234);
    rd_lit(16'h0010, 16'h1234, "ram_load");
    step(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0000, "no_read_zero");
    rd_lit(16'h0011, 16'h1234, "ram_odd_byte");

    // LED, reset, mid-store reset, IN is read-only.
    wr_word(16'hFF00, 16'h00A5);
    chk("led_a5", {8'h00, led}, 16'h00A5);
    rd_lit(16'hFF00, 16'h00A5, "led_read");
    step(1'b1, 1'b0, 1'b1, 16'h0010, 16'hDEAD, 1'b0, 16'h0000, "rst_store");
    chk("led_after_reset", {8'h00, led}, 16'h0000);
    rd_lit(16'h0010, 16'h1234, "store_in_reset_dropped");
    wr_word(16'hFF02, 16'hFFFF);
    rd_lit(16'hFF02, 16'h0000, "in_readonly");
    chk("in_write_no_err", {15'h0, err_unmapped}, 16'h0000);

    // CYC: clear then read five cycles later.
    wr_word(16'hFF04, 16'h5555);
    for (int i = 0; i < 4; i++) idle();
    rd_lit(16'hFF04, 16'h0004, "cyc_after_clear");

    // TICK with PRESCALE=4.
    wr_word(16'hFF06, 16'h0000);
    for (int i = 0; i < 12; i++) idle();
    rd_lit(16'hFF06, 16'h0003, "tick_12");

    // Switch path latency (and debounce latency when enabled).
    pins = 8'h0A;
    for (int i = 0; i <= 2 + DBL; i++)
      rd_lit(16'hFF02, (i >= 2 + DBL) ? 16'h000A : 16'h0000, "sw_latency");

    // One-cycle glitch on btn[0].
    pins = 8'h1A;
    rd_lit(16'hFF02, 16'h000A, "glitch_0");
    pins = 8'h0A;
    for (int i = 1; i <= DBL + 4; i++)
      rd_lit(16'hFF02, (DBL == 0 && i == 2) ? 16'h001A : 16'h000A, "glitch");

    // Unmapped access and read-during-write.
    rd_lit(16'h8000, 16'h0000, "unmapped_read");
    chk("err_set", {15'h0, err_unmapped}, 16'h0001);
    idle();
    idle();
    chk("err_held", {15'h0, err_unmapped}, 16'h0001);
    step(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 16'h1234, "rw_old_data");
    rd_lit(16'h0010, 16'hBEEF, "rw_new_data");

    // CYC wrap: clear, then 65535 cycles later it reads 0xFFFF, then 0x0000.
    wr_word(16'hFF04, 16'h0000);
    for (int i = 0; i < 65535; i++) idle();
    rd_lit(16'hFF04, 16'hFFFF, "cyc_ffff");
    rd_lit(16'hFF04, 16'h0000, "cyc_wrap");

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: ad = 16'($urandom_range(0, 2*RW - 1));
        4:          ad = 16'hFF00 | 16'($urandom_range(0, 1));
        5:          ad = 16'hFF02;
        6:          ad = 16'hFF04;
        7:          ad = 16'hFF06;
        8:          ad = 16'($urandom_range(32'h0100, 32'hFEFF));
        default:    ad = 16'($urandom_range(32'hFF08, 32'hFFFF));
      endcase
      r  = 1'($urandom_range(0, 1));
      w  = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) pins = 8'($urandom);
      step(rs, r, w, ad, 16'($urandom), 1'b0, 16'h0000, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
